branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor sitting directly upstream of the fetch stage. Supplies the predicted next PC for the current fetch PC.
- Consumes resolved branch/jump outcomes from the execute stage, then trains itself and flags mispredictions so fetch can redirect.
- Direct-mapped BTB plus a 2-bit saturating-counter BHT, with saturating performance counters.

Parameters:
- IDX_BITS, 4, index width; table depth = 2**IDX_BITS entries.
- XLEN, 32, address/data width.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- PCF  in  XLEN  current fetch PC
- PredTakenF  out  1  fetch-side taken prediction
- PredTargetF  out  XLEN  predicted next PC for fetch
- UpdateE  in  1  execute holds a resolved branch/jump this cycle
- JumpE  in  1  resolved instruction is unconditional (jal/jalr)
- TakenE  in  1  actual outcome
- PCE  in  XLEN  PC of the resolved instruction
- PCPlus4E  in  XLEN  PCE+4
- PCTargetE  in  XLEN  actual target
- PredTakenE  in  1  prediction made for this instruction, piped from fetch
- PredTargetE  in  XLEN  predicted target, piped from fetch
- MispredictE  out  1  redirect required
- PCRedirectE  out  XLEN  correct next PC
- BranchCount  out  CNT_W  resolved updates seen
- MissCount  out  CNT_W  mispredictions seen

Behaviour:
- Indexing and tags:
  - idx = PC[IDX_BITS+1:2].
  - tag = PC[XLEN-1:IDX_BITS+2].
  - Per entry: valid, tag, target, 2-bit counter.
- Lookup (combinational from table registers):
  - hit = valid[idx] & tag match.
  - PredTakenF = hit & ctr[idx][1].
  - PredTargetF = PredTakenF ? target[idx] : PCF+4.
- Mispredict (combinational):
  - MispredictE = UpdateE & ((TakenE != PredTakenE) | (TakenE & PredTakenE & PredTargetE != PCTargetE)).
  - PCRedirectE = TakenE ? PCTargetE : PCPlus4E, driven at all times.
  - MispredictE = 0 when UpdateE = 0.
- Training (rising edge, only when UpdateE = 1), at index idx(PCE):
  - TakenE = 1: write valid = 1, tag(PCE), target = PCTargetE. Counter: JumpE ? 2'b11 : sat_inc(ctr).
  - TakenE = 0 with a tag hit: counter sat_dec, BTB entry retained.
  - TakenE = 0 without a tag hit: no change (no allocation).
  - Counters saturate at 0 and 3. A taken update to a tag-mismatched entry replaces it and its counter becomes 2'b10 (2'b11 if JumpE).
- Write visibility: an update is visible to lookups from the next cycle. When PCF and PCE hit the same index in one cycle, the lookup returns the pre-update value; there is no bypass.
- Statistics:
  - BranchCount += 1 per UpdateE.
  - MissCount += 1 per MispredictE.
  - Both saturate at all-ones and never wrap.
- Reset (rst low, any time including mid-update):
  - Immediately clears all valid bits, sets all counters to 2'b01, and zeroes both statistics counters.
  - Targets and tags need not be reset.
  - Consequently PredTakenF = 0 and PredTargetF = PCF+4 during and after reset until training.
  - An update coinciding with reset release edge is ignored while rst is low.
- Latency: prediction 0 cycles (same cycle as PCF); training 1 cycle.

Decomposition:
- Shared package holds:
  - XLEN;
  - counter encodings: SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11;
  - the reset counter value;
  - functions idx_of(pc) and tag_of(pc).
- One sub-module is natural: bp_sat_counter (2-bit saturating next-state logic with inc/dec/force-strong inputs), instantiated per update path.
- Table storage stays in the top module as register arrays.

Test Plan:
- Reset, PCF = 0x100 -> PredTakenF = 0, PredTargetF = 0x104; BranchCount = MissCount = 0.
- Update PCE = 0x100, TakenE = 1, PCTargetE = 0x80, PredTakenE = 0 -> MispredictE = 1, PCRedirectE = 0x80. Next cycle PCF = 0x100 -> PredTakenF = 1, PredTargetF = 0x80 (counter 10). MissCount = 1.
- Three taken updates at 0x100 then one not-taken -> counter 11 then 10, still predicts taken. A second not-taken -> 01 and PredTakenF = 0; the not-taken update carried PredTakenE = 1, so MispredictE = 1 and PCRedirectE = PCPlus4E = 0x104.
- Alias: after training 0x100, PCF = 0x140 (same idx 0, different tag) -> PredTakenF = 0. A taken update at 0x140 with target 0x200 evicts the entry, and 0x100 then misses.
- JumpE = 1 at 0x40 taken, target 0x300, PredTakenE = 1, PredTargetE = 0x2F0 -> MispredictE = 1 (target mismatch), counter forced to 11, new target 0x300.
- Assert rst low during an UpdateE cycle after training -> all predictions drop to not-taken immediately and counters read 0. With UpdateE = 0, MispredictE = 0 regardless of the other inputs.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: counter encodings, the reset
// counter value and the PC-to-index/tag helpers.
package branch_predictor_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam logic [1:0] CTR_RESET = WNT;

  // Word-aligned index; callers truncate to their own index width.
  function automatic logic [XLEN-1:0] idx_of(input logic [XLEN-1:0] pc, input int idx_bits);
    return (pc >> 2) & ((XLEN'(1) << idx_bits) - XLEN'(1));
  endfunction

  function automatic logic [XLEN-1:0] tag_of(input logic [XLEN-1:0] pc, input int idx_bits);
    return pc >> (idx_bits + 2);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic of a 2-bit saturating direction counter.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       inc,
  input  logic       dec,
  input  logic       force_strong,
  output logic [1:0] nxt
);

  // Saturating step; force_strong wins over inc/dec.
  always_comb begin
    nxt = ctr;
    if (force_strong) begin
      nxt = ST;
    end else if (inc) begin
      nxt = (ctr == ST) ? ST : ctr + 2'b01;
    end else if (dec) begin
      nxt = (ctr == SNT) ? SNT : ctr - 2'b01;
    end else begin
      nxt = ctr;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit BHT: same-cycle fetch prediction, execute-stage
// training, misprediction detection and saturating statistics.
module branch_predictor #(
  parameter int IDX_BITS = 4,
  parameter int XLEN     = 32,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  PCF,
  output logic             PredTakenF,
  output logic [XLEN-1:0]  PredTargetF,
  input  logic             UpdateE,
  input  logic             JumpE,
  input  logic             TakenE,
  input  logic [XLEN-1:0]  PCE,
  input  logic [XLEN-1:0]  PCPlus4E,
  input  logic [XLEN-1:0]  PCTargetE,
  input  logic             PredTakenE,
  input  logic [XLEN-1:0]  PredTargetE,
  output logic             MispredictE,
  output logic [XLEN-1:0]  PCRedirectE,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MissCount
);
  import branch_predictor_pkg::*;

  localparam int DEPTH = 2 ** IDX_BITS;
  localparam int TAG_W = XLEN - IDX_BITS - 2;

  logic              valid_r  [DEPTH];
  logic [TAG_W-1:0]  tag_r    [DEPTH];
  logic [XLEN-1:0]   target_r [DEPTH];
  logic [1:0]        ctr_r    [DEPTH];
  logic [CNT_W-1:0]  branch_count_r;
  logic [CNT_W-1:0]  miss_count_r;

  logic [IDX_BITS-1:0] f_idx_s;
  logic [TAG_W-1:0]    f_tag_s;
  logic                f_hit_s;
  logic [IDX_BITS-1:0] e_idx_s;
  logic [TAG_W-1:0]    e_tag_s;
  logic                e_hit_s;
  logic [1:0]          e_ctr_base_s;
  logic [1:0]          e_ctr_nxt_s;
  logic                mispredict_s;

  assign f_idx_s = IDX_BITS'(idx_of(PCF, IDX_BITS));
  assign f_tag_s = TAG_W'(tag_of(PCF, IDX_BITS));
  assign e_idx_s = IDX_BITS'(idx_of(PCE, IDX_BITS));
  assign e_tag_s = TAG_W'(tag_of(PCE, IDX_BITS));

  // Fetch lookup reads the table registers only, so same-index updates show next cycle.
  always_comb begin
    f_hit_s    = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);
    PredTakenF = f_hit_s && ctr_r[f_idx_s][1];
    if (PredTakenF) begin
      PredTargetF = target_r[f_idx_s];
    end else begin
      PredTargetF = PCF + XLEN'(4);
    end
  end

  // Resolution check against what fetch predicted.
  always_comb begin
    mispredict_s = UpdateE &&
                   ((TakenE != PredTakenE) ||
                    (TakenE && PredTakenE && (PredTargetE != PCTargetE)));
    if (TakenE) begin
      PCRedirectE = PCTargetE;
    end else begin
      PCRedirectE = PCPlus4E;
    end
  end

  assign MispredictE = mispredict_s;

  // A replaced or empty entry trains as if from WNT, so a taken allocation lands on WT.
  assign e_hit_s      = valid_r[e_idx_s] && (tag_r[e_idx_s] == e_tag_s);
  assign e_ctr_base_s = e_hit_s ? ctr_r[e_idx_s] : CTR_RESET;

  bp_sat_counter u_sat_counter (
    .ctr          (e_ctr_base_s),
    .inc          (TakenE & ~JumpE),
    .dec          (~TakenE),
    .force_strong (TakenE & JumpE),
    .nxt          (e_ctr_nxt_s)
  );

  // Table training from the execute stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= '0;
        ctr_r[i]    <= CTR_RESET;
      end
    end else if (UpdateE) begin
      if (TakenE) begin
        valid_r[e_idx_s]  <= 1'b1;
        tag_r[e_idx_s]    <= e_tag_s;
        target_r[e_idx_s] <= PCTargetE;
        ctr_r[e_idx_s]    <= e_ctr_nxt_s;
      end else if (e_hit_s) begin
        ctr_r[e_idx_s]    <= e_ctr_nxt_s;
      end
    end
  end

  // Statistics counters hold at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_count_r <= '0;
      miss_count_r   <= '0;
    end else begin
      if (UpdateE && (branch_count_r != {CNT_W{1'b1}})) begin
        branch_count_r <= branch_count_r + CNT_W'(1);
      end
      if (mispredict_s && (miss_count_r != {CNT_W{1'b1}})) begin
        miss_count_r <= miss_count_r + CNT_W'(1);
      end
    end
  end

  assign BranchCount = branch_count_r;
  assign MissCount   = miss_count_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized bench for branch_predictor against a table-level model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        UpdateE, JumpE, TakenE, PredTakenE;
  logic [31:0] PCE, PCPlus4E, PCTargetE, PredTargetE;
  logic        MispredictE;
  logic [31:0] PCRedirectE;
  logic [31:0] BranchCount, MissCount;

  int checks = 0;
  int errors = 0;

  // Model: 16 entries keyed by (pc/4)%16, tag is pc/64, counter kept as an int 0..3.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  longint      m_bc, m_mc;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(4), .XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .UpdateE(UpdateE), .JumpE(JumpE), .TakenE(TakenE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .PCTargetE(PCTargetE), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .MispredictE(MispredictE), .PCRedirectE(PCRedirectE),
    .BranchCount(BranchCount), .MissCount(MissCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == pc / 64);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic bit m_misp();
    if (!UpdateE) return 1'b0;
    if (TakenE != PredTakenE) return 1'b1;
    return TakenE && PredTakenE && (PredTargetE != PCTargetE);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic m_train();
    int i;
    i = m_idx(PCE);
    if (!UpdateE) return;
    m_bc = (m_bc == 64'hFFFF_FFFF) ? m_bc : m_bc + 1;
    if (m_misp()) m_mc = (m_mc == 64'hFFFF_FFFF) ? m_mc : m_mc + 1;
    if (TakenE) begin
      if (JumpE)          m_ctr[i] = 3;
      else if (m_hit(PCE)) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
      else                m_ctr[i] = 2;
      m_valid[i] = 1'b1;
      m_tag[i]   = PCE / 64;
      m_tgt[i]   = PCTargetE;
    end else if (m_hit(PCE)) begin
      m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_tgt;
    exp_tgt = m_pred(PCF) ? m_tgt[m_idx(PCF)] : PCF + 32'd4;
    chk({tag, ".pred"}, {31'd0, PredTakenF}, {31'd0, m_pred(PCF)});
    chk({tag, ".target"}, PredTargetF, exp_tgt);
    chk({tag, ".misp"}, {31'd0, MispredictE}, {31'd0, m_misp()});
    chk({tag, ".redir"}, PCRedirectE, TakenE ? PCTargetE : PCPlus4E);
    chk({tag, ".bcount"}, BranchCount, m_bc[31:0]);
    chk({tag, ".mcount"}, MissCount, m_mc[31:0]);
  endtask

  task automatic drive(input logic [31:0] pcf, input bit upd, input bit jmp, input bit tkn,
                       input logic [31:0] pce, input logic [31:0] tgt,
                       input bit ptk, input logic [31:0] ptgt);
    PCF = pcf; UpdateE = upd; JumpE = jmp; TakenE = tkn;
    PCE = pce; PCPlus4E = pce + 32'd4; PCTargetE = tgt;
    PredTakenE = ptk; PredTargetE = ptgt;
  endtask

  // Inputs are set just after a rising edge; check mid-cycle, then train the model at the edge.
  task automatic cycle(input string tag);
    #2;
    check_all(tag);
    @(posedge clk);
    if (rst) m_train();
    #1;
  endtask

  initial begin
    logic [31:0] pc, pf, tg;
    bit tk, pt;

    rst = 1'b0;
    m_reset();
    drive(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #3;
    chk("reset.pred", {31'd0, PredTakenF}, 32'd0);
    chk("reset.target", PredTargetF, 32'h104);
    chk("reset.counts", BranchCount | MissCount, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // First taken update at 0x100 allocates with WT.
    drive(32'h100, 1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0);
    #2;
    chk("alloc.misp", {31'd0, MispredictE}, 32'd1);
    chk("alloc.redir", PCRedirectE, 32'h80);
    chk("alloc.pred_same_cycle", {31'd0, PredTakenF}, 32'd0);
    @(posedge clk); m_train(); #1;
    drive(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2;
    chk("alloc.next.pred", {31'd0, PredTakenF}, 32'd1);
    chk("alloc.next.target", PredTargetF, 32'h80);
    chk("alloc.misscount", MissCount, 32'd1);
    @(posedge clk); #1;

    for (int k = 0; k < 3; k++) begin
      drive(32'h100, 1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b1, 32'h80);
      cycle("taken3");
    end
    drive(32'h100, 1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
    cycle("nt1");
    drive(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2;
    chk("nt1.still_taken", {31'd0, PredTakenF}, 32'd1);
    @(posedge clk); #1;
    drive(32'h100, 1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
    #2;
    chk("nt2.misp", {31'd0, MispredictE}, 32'd1);
    chk("nt2.redir", PCRedirectE, 32'h104);
    @(posedge clk); m_train(); #1;
    drive(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2;
    chk("nt2.pred_off", {31'd0, PredTakenF}, 32'd0);
    @(posedge clk); #1;

    // Retrain 0x100, then alias at 0x140 evicts it.
    drive(32'h100, 1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0);
    cycle("retrain");
    drive(32'h140, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2;
    chk("alias.miss", {31'd0, PredTakenF}, 32'd0);
    chk("alias.target", PredTargetF, 32'h144);
    @(posedge clk); #1;
    drive(32'h140, 1'b1, 1'b0, 1'b1, 32'h140, 32'h200, 1'b0, 32'h0);
    cycle("evict");
    drive(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2;
    chk("evict.old_miss", {31'd0, PredTakenF}, 32'd0);
    @(posedge clk); #1;
    drive(32'h140, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    cycle("evict.new_hit");

    // Jump with target mismatch forces a strong counter.
    drive(32'h40, 1'b1, 1'b1, 1'b1, 32'h40, 32'h300, 1'b1, 32'h2F0);
    #2;
    chk("jump.misp", {31'd0, MispredictE}, 32'd1);
    @(posedge clk); m_train(); #1;
    drive(32'h40, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h300);
    cycle("jump.dec");
    drive(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2;
    chk("jump.strong_after_dec", {31'd0, PredTakenF}, 32'd1);
    chk("jump.target", PredTargetF, 32'h300);
    @(posedge clk); #1;

    // Random traffic over 32 PCs (16 indices x 2 tags) to exercise aliasing.
    for (int n = 0; n < 400; n++) begin
      pc = 32'($urandom_range(0, 31)) * 32'd4;
      pf = 32'($urandom_range(0, 31)) * 32'd4;
      tg = 32'($urandom_range(0, 255)) * 32'd4;
      tk = 1'($urandom_range(0, 1));
      pt = ($urandom_range(0, 3) != 0) ? m_pred(pc) : 1'($urandom_range(0, 1));
      drive(pf, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0), tk, pc, tg, pt,
            pt ? (($urandom_range(0, 3) != 0) ? m_tgt[m_idx(pc)] : tg) : 32'h0);
      cycle("rand");
    end

    // Reset asserted mid-cycle during an update clears state immediately.
    drive(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2;
    chk("prerst.trained", {31'd0, PredTakenF}, {31'd0, m_pred(32'h40)});
    @(posedge clk); #1;
    drive(32'h40, 1'b1, 1'b1, 1'b1, 32'h40, 32'h500, 1'b0, 32'h0);
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    chk("rst.pred", {31'd0, PredTakenF}, 32'd0);
    chk("rst.target", PredTargetF, 32'h44);
    chk("rst.bcount", BranchCount, 32'd0);
    chk("rst.mcount", MissCount, 32'd0);
    @(posedge clk); #1;
    chk("rst.edge_ignored", {31'd0, PredTakenF}, 32'd0);
    rst = 1'b1;
    drive(32'h40, 1'b0, 1'b1, 1'b1, 32'h40, 32'h500, 1'b0, 32'h123);
    #2;
    chk("noupd.misp", {31'd0, MispredictE}, 32'd0);
    chk("noupd.redir", PCRedirectE, 32'h500);
    @(posedge clk); #1;
    cycle("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
